pcpu_memsys: RTL and testbench
==============================

PCPU_MEMSYS -- requirements
Module: pcpu_memsys

Interface
REQ-001 Parameter: none; memory geometry fixed at 256 x 16 instruction memory (IMEM) and 256 x 16 data memory (DMEM).
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 i_addr  input  8  CPU instruction fetch address.
REQ-005 i_datain  output  16  instruction word returned to the CPU.
REQ-006 d_addr  input  8  CPU data address.
REQ-007 d_dataout  input  16  CPU store data.
REQ-008 d_we  input  1  CPU store strobe.
REQ-009 d_datain  output  16  load data returned to the CPU.
REQ-010 ld_start  input  1  begin a load burst; 1-cycle pulse.
REQ-011 ld_sel  input  1  burst target: 0 = IMEM, 1 = DMEM; sampled with ld_start.
REQ-012 ld_base  input  8  burst start address; sampled with ld_start.
REQ-013 ld_valid  input  1  host word valid.
REQ-014 ld_data  input  16  host word.
REQ-015 ld_last  input  1  marks the final word of the burst; qualified by ld_valid.
REQ-016 ld_ready  output  1  block accepts a host word this cycle.
REQ-017 ld_count  output  9  words accepted in the current/last burst.
REQ-018 run_go  input  1  release the CPU.
REQ-019 halt  input  1  stop the CPU.
REQ-020 cpu_enable  output  1  drives the CPU enable; 1 only in RUN.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN; state encoding is free.
REQ-022 IDLE: ld_start=1 -> LOAD; else run_go=1 -> RUN; ld_start SHALL win when both are asserted together.
REQ-023 On entering LOAD: address counter <= ld_base, target <= ld_sel, ld_count <= 0.
REQ-024 LOAD: ld_ready SHALL be 1; a handshake is ld_valid & ld_ready.
REQ-025 Each handshake SHALL write ld_data into the target memory at the counter.
REQ-026 Each handshake SHALL increment the counter mod 256 (255 -> 0 wraps; later words overwrite earlier ones).
REQ-027 Each handshake SHALL increment ld_count, saturating at 256.
REQ-028 A handshake with ld_last=1 SHALL return the FSM to IDLE on the same edge; ld_count holds its final value until the next ld_start.
REQ-029 ld_last without ld_valid SHALL be ignored; ld_start, run_go and halt SHALL be ignored in LOAD.
REQ-030 RUN: cpu_enable=1; halt=1 -> IDLE, with cpu_enable low from the next cycle; ld_start and run_go SHALL be ignored in RUN.
REQ-031 i_datain SHALL equal IMEM[i_addr] combinationally in all states.
REQ-032 d_datain SHALL equal DMEM[d_addr] combinationally in all states.
REQ-033 CPU store: in RUN, d_we=1 writes d_dataout to DMEM[d_addr] at the edge.
REQ-034 A read of the address being stored in the same cycle SHALL return the old value; the new value is visible the following cycle.
REQ-035 d_we outside RUN SHALL be ignored, so a load burst is never corrupted by the CPU.
REQ-036 ld_ready SHALL be 0 and cpu_enable SHALL be 0 in IDLE.

Reset
REQ-037 While reset is asserted: FSM = IDLE, cpu_enable = 0, ld_ready = 0, ld_count = 0, address counter = 0, target = IMEM, and all 512 memory words = 0; hence i_datain = d_datain = 0.
REQ-038 Reset asserted during LOAD or RUN SHALL abort immediately; no write SHALL occur on the edge coincident with reset.

Verification
REQ-039 Reset: assert reset mid-burst -> cpu_enable=0, ld_ready=0, ld_count=0, i_datain=0 for i_addr=0x10 before any clock edge.
REQ-040 IMEM load: ld_start, ld_sel=0, ld_base=0x00; 4 words 0x1111..0x4444, last on word 4 -> IDLE, ld_count=4, i_addr=0x03 reads 0x4444.
REQ-041 Wrap: ld_sel=1, ld_base=0xFE; words 0xAAAA, 0xBBBB, 0xCCCC (last) -> DMEM[0xFE]=0xAAAA, DMEM[0xFF]=0xBBBB, DMEM[0x00]=0xCCCC, ld_count=3.
REQ-042 Backpressure gaps: ld_valid low for 2 cycles mid-burst -> no writes during the gap, ld_count unchanged, ld_ready stays 1.
REQ-043 Run/store: run_go -> cpu_enable=1; d_we=1, d_addr=0x20, d_dataout=0x5A5A -> same-cycle d_datain=old value, next cycle 0x5A5A; halt -> cpu_enable=0 next cycle.
REQ-044 Priority/ignore: ld_start with run_go in IDLE -> LOAD; d_we=1 in LOAD -> DMEM unchanged; ld_start in RUN -> stays RUN.

Source files
------------

// File: rtl/pcpu_memsys.sv
// Program-loader memory system: 256x16 IMEM and DMEM, host burst loader,
// and CPU run/halt control with data-side stores while running.
module pcpu_memsys (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic [7:0]  d_addr,
  input  logic [15:0] d_dataout,
  input  logic        d_we,
  output logic [15:0] d_datain,
  input  logic        ld_start,
  input  logic        ld_sel,
  input  logic [7:0]  ld_base,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [8:0]  ld_count,
  input  logic        run_go,
  input  logic        halt,
  output logic        cpu_enable
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        sel_q, sel_d;
  logic [8:0]  cnt_q, cnt_d;

  logic [15:0] imem_q [256];
  logic [15:0] dmem_q [256];

  logic        hs;
  logic        im_we;
  logic        dm_we;
  logic [7:0]  dm_waddr;
  logic [15:0] dm_wdata;

  assign ld_ready   = (state_q == LOAD);
  assign cpu_enable = (state_q == RUN);
  assign ld_count   = cnt_q;
  assign hs         = ld_valid & ld_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          addr_d  = ld_base;
          sel_d   = ld_sel;
          cnt_d   = '0;
        end else if (run_go) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (hs) begin
          addr_d = addr_q + 8'd1;
          if (cnt_q != 9'd256)
            cnt_d = cnt_q + 9'd1;
          if (ld_last)
            state_d = IDLE;
        end
      end
      RUN: begin
        if (halt)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader and CPU stores never overlap: they live in different states.
  always_comb begin
    im_we    = hs & ~sel_q;
    dm_we    = 1'b0;
    dm_waddr = addr_q;
    dm_wdata = ld_data;
    if (hs && sel_q) begin
      dm_we = 1'b1;
    end else if (state_q == RUN && d_we) begin
      dm_we    = 1'b1;
      dm_waddr = d_addr;
      dm_wdata = d_dataout;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        imem_q[i] <= '0;
        dmem_q[i] <= '0;
      end
    end else begin
      if (im_we)
        imem_q[addr_q] <= ld_data;
      if (dm_we)
        dmem_q[dm_waddr] <= dm_wdata;
    end
  end

  assign i_datain = imem_q[i_addr];
  assign d_datain = dmem_q[d_addr];

endmodule

// File: tb/tb_pcpu_memsys.sv
// Scoreboard bench for pcpu_memsys: stimulus queues expectations,
// a monitor process samples the DUT and compares.
module tb_pcpu_memsys;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        ld_start;
  logic        ld_sel;
  logic [7:0]  ld_base;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [8:0]  ld_count;
  logic        run_go;
  logic        halt;
  logic        cpu_enable;

  pcpu_memsys dut (
    .clock      (clock),
    .reset      (reset),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .d_addr     (d_addr),
    .d_dataout  (d_dataout),
    .d_we       (d_we),
    .d_datain   (d_datain),
    .ld_start   (ld_start),
    .ld_sel     (ld_sel),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_count   (ld_count),
    .run_go     (run_go),
    .halt       (halt),
    .cpu_enable (cpu_enable)
  );

  always #5 clock = ~clock;

  localparam int K_CEN = 0;
  localparam int K_RDY = 1;
  localparam int K_CNT = 2;
  localparam int K_I   = 3;
  localparam int K_D   = 4;

  string       nq[$];
  int          kq[$];
  logic [15:0] vq[$];
  event        smp_ev;
  int          total = 0;
  int          passed = 0;

  task automatic expect_v(input int k, input logic [15:0] v,
                          input string n);
    nq.push_back(n);
    kq.push_back(k);
    vq.push_back(v);
  endtask

  task automatic smp();
    #1;
    -> smp_ev;
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    @(negedge clock);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin : monitor
    string       n;
    int          k;
    logic [15:0] v;
    logic [15:0] act;
    forever begin
      @(smp_ev);
      while (kq.size() != 0) begin
        n = nq.pop_front();
        k = kq.pop_front();
        v = vq.pop_front();
        case (k)
          K_CEN:   act = {15'd0, cpu_enable};
          K_RDY:   act = {15'd0, ld_ready};
          K_CNT:   act = {7'd0, ld_count};
          K_I:     act = i_datain;
          default: act = d_datain;
        endcase
        total++;
        if (act === v)
          passed++;
        else
          $display("FAIL %s: got %h expected %h", n, act, v);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    i_addr = 8'h10; d_addr = '0; d_dataout = '0; d_we = 1'b0;
    ld_start = 1'b0; ld_sel = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    run_go = 1'b0; halt = 1'b0;

    expect_v(K_CEN, 16'd0, "rst_cen");
    expect_v(K_RDY, 16'd0, "rst_rdy");
    expect_v(K_CNT, 16'd0, "rst_cnt");
    expect_v(K_I,   16'd0, "rst_imem");
    smp();
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    expect_v(K_RDY, 16'd0, "idle_rdy");
    expect_v(K_CEN, 16'd0, "idle_cen");
    smp();

    // IMEM burst with a two-cycle gap (and a stray ld_last without valid)
    ld_start = 1'b1; ld_sel = 1'b0; ld_base = 8'h00;
    @(negedge clock); ld_start = 1'b0;
    expect_v(K_RDY, 16'd1, "load_rdy");
    expect_v(K_CNT, 16'd0, "load_cnt0");
    smp();
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    i_addr = 8'h02;
    ld_last = 1'b1;
    for (int g = 0; g < 2; g++) begin
      @(negedge clock);
      expect_v(K_CNT, 16'd2, "gap_cnt");
      expect_v(K_RDY, 16'd1, "gap_rdy");
      expect_v(K_I,   16'd0, "gap_nowrite");
      smp();
    end
    ld_last = 1'b0;
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b1);
    i_addr = 8'h03;
    expect_v(K_RDY, 16'd0,     "imem_done_rdy");
    expect_v(K_CNT, 16'd4,     "imem_cnt");
    expect_v(K_I,   16'h4444,  "imem_03");
    smp();
    @(negedge clock); i_addr = 8'h00;
    expect_v(K_I, 16'h1111, "imem_00");
    smp();
    @(negedge clock); i_addr = 8'h02;
    expect_v(K_I, 16'h3333, "imem_02");
    smp();

    // DMEM wrap burst; ld_start beats run_go, d_we ignored outside RUN
    @(negedge clock);
    ld_start = 1'b1; run_go = 1'b1; ld_sel = 1'b1; ld_base = 8'hFE;
    d_we = 1'b1; d_addr = 8'h50; d_dataout = 16'hDEAD;
    @(negedge clock); ld_start = 1'b0; run_go = 1'b0;
    expect_v(K_RDY, 16'd1, "prio_rdy");
    expect_v(K_CEN, 16'd0, "prio_cen");
    smp();
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b1);
    d_we = 1'b0;
    expect_v(K_CNT, 16'd3, "wrap_cnt");
    expect_v(K_RDY, 16'd0, "wrap_done_rdy");
    expect_v(K_D,   16'd0, "dwe_ignored");
    smp();
    @(negedge clock); d_addr = 8'hFE; i_addr = 8'hFE;
    expect_v(K_D, 16'hAAAA, "dmem_fe");
    expect_v(K_I, 16'd0,    "imem_fe_untouched");
    smp();
    @(negedge clock); d_addr = 8'hFF;
    expect_v(K_D, 16'hBBBB, "dmem_ff");
    smp();
    @(negedge clock); d_addr = 8'h00;
    expect_v(K_D, 16'hCCCC, "dmem_00");
    smp();

    // Run, store with read-old-value, ld_start ignored, halt
    @(negedge clock); run_go = 1'b1;
    @(negedge clock); run_go = 1'b0;
    d_addr = 8'h20; d_we = 1'b1; d_dataout = 16'h5A5A;
    expect_v(K_CEN, 16'd1, "run_cen");
    expect_v(K_RDY, 16'd0, "run_rdy");
    expect_v(K_D,   16'd0, "store_old");
    smp();
    @(negedge clock); d_we = 1'b0;
    expect_v(K_D, 16'h5A5A, "store_new");
    smp();
    ld_start = 1'b1; ld_sel = 1'b0; ld_base = 8'h00;
    @(negedge clock); ld_start = 1'b0;
    expect_v(K_CEN, 16'd1, "run_ignore_start");
    expect_v(K_RDY, 16'd0, "run_ignore_rdy");
    expect_v(K_CNT, 16'd3, "run_cnt_hold");
    smp();
    halt = 1'b1;
    expect_v(K_CEN, 16'd1, "halt_same_cycle");
    smp();
    @(negedge clock); halt = 1'b0;
    expect_v(K_CEN, 16'd0, "halt_next_cycle");
    smp();

    // 257-word burst: count saturates, address wraps and overwrites
    @(negedge clock);
    ld_start = 1'b1; ld_sel = 1'b0; ld_base = 8'h00;
    @(negedge clock); ld_start = 1'b0;
    for (int w = 0; w <= 256; w++)
      send(16'(w), w == 256);
    i_addr = 8'h00;
    expect_v(K_CNT, 16'd256,  "sat_cnt");
    expect_v(K_I,   16'h0100, "sat_overwrite");
    smp();
    @(negedge clock); i_addr = 8'hFF;
    expect_v(K_I, 16'h00FF, "sat_imem_ff");
    smp();

    // Reset mid-burst aborts immediately
    @(negedge clock);
    ld_start = 1'b1; ld_sel = 1'b0; ld_base = 8'h10;
    @(negedge clock); ld_start = 1'b0;
    send(16'h7777, 1'b0);
    i_addr = 8'h10; d_addr = 8'h20;
    expect_v(K_I,   16'h7777, "pre_rst_word");
    expect_v(K_RDY, 16'd1,    "pre_rst_rdy");
    smp();
    ld_valid = 1'b1; ld_data = 16'h9999;
    #1 reset = 1'b1;
    expect_v(K_CEN, 16'd0, "mid_rst_cen");
    expect_v(K_RDY, 16'd0, "mid_rst_rdy");
    expect_v(K_CNT, 16'd0, "mid_rst_cnt");
    expect_v(K_I,   16'd0, "mid_rst_imem");
    expect_v(K_D,   16'd0, "mid_rst_dmem");
    smp();
    @(negedge clock); reset = 1'b0; ld_valid = 1'b0;
    i_addr = 8'h11;
    expect_v(K_I,   16'd0, "rst_edge_nowrite");
    expect_v(K_RDY, 16'd0, "post_rst_idle");
    smp();

    @(negedge clock);
    if (kq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", kq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
